regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports, minimum 1.
REQ-004 SHALL have parameter ZERO_R0, default 1: when 1, register 0 is hardwired to zero.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-009 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-010 SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: packed read addresses; port k occupies slice [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd_data, output, NUM_RD*DATA_W bits: packed registered read data, sliced the same way as rd_addr.
REQ-012 SHALL have port clr_req, input, 1 bit: start a full-array clear sweep.
REQ-013 SHALL have port busy, output, 1 bit: high while a clear sweep is in progress.
REQ-014 SHALL have port clr_done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-015 SHALL have port wr_drop, output, 1 bit: one-cycle pulse when an external write is discarded because busy is high.

Function
REQ-016 SHALL register read data with 1-cycle latency: rd_data[k] after edge N equals the content of rd_addr[k] as sampled at edge N.
REQ-017 SHALL apply write-first bypass: when a write to address A commits at edge N and rd_addr[k]==A at edge N, rd_data[k] SHALL show the new data.
REQ-018 SHALL bypass independently on every read port; several ports addressing the same register all receive the same value.
REQ-019 SHALL, when ZERO_R0=1, discard writes to address 0 and return 0 on reads of address 0; no bypass applies to address 0.
REQ-020 SHALL use FSM states IDLE and CLEAR.
REQ-021 SHALL move IDLE->CLEAR on clr_req==1, with the sweep pointer at 0.
REQ-022 SHALL, in CLEAR, write 0 to the pointed register each cycle and then increment the pointer.
REQ-023 SHALL move CLEAR->IDLE after the write to address DEPTH-1 and pulse clr_done in the first cycle back in IDLE.
REQ-024 SHALL complete a sweep in exactly DEPTH cycles in CLEAR; busy SHALL be high in exactly those cycles.
REQ-025 SHALL detect sweep termination by comparing the pointer against DEPTH-1; no pointer wrap-around is permitted.
REQ-026 SHALL ignore clr_req while busy is high; no queuing and no restart.
REQ-027 SHALL discard an external wr_en while busy is high and pulse wr_drop in the following cycle.
REQ-028 SHALL let sweep writes drive the same bypass as external writes.
REQ-029 SHALL, when wr_en and clr_req are both high in IDLE, commit the write at that edge and start the sweep, so the sweep later zeroes that register.
REQ-030 SHALL keep reads fully functional during CLEAR.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously force every register, every rd_data slice, the sweep pointer, busy, clr_done and wr_drop to 0, and force the FSM to IDLE.
REQ-032 SHALL abort any sweep in progress on reset; clr_done SHALL NOT pulse for an aborted sweep.
REQ-033 SHALL resume normal operation at the first rising clk edge after rst_n deasserts.

Structure
REQ-034 SHALL place the FSM state enum (IDLE, CLEAR) in shared package regfile_pkg.
REQ-035 SHALL place the DEPTH derivation helper in regfile_pkg.
REQ-036 SHALL implement the sweep FSM and pointer in sub-module regfile_clr_seq, outputs busy, clr_done, clr_addr and clr_we.
REQ-037 SHALL keep the array, write muxing, bypass and read ports in regfile_mp.

Verification (DATA_W=8, ADDR_W=3, NUM_RD=2, ZERO_R0=1)
REQ-038 SHALL cover write-then-read: write R5=0xA7; next cycle rd_addr0=5 -> rd_data0=0xA7 one edge later.
REQ-039 SHALL cover bypass: write R3=0x3C at edge N with rd_addr0=rd_addr1=3 -> both ports =0x3C after edge N.
REQ-040 SHALL cover R0: write R0=0xFF -> reads of R0 return 0x00.
REQ-041 SHALL cover a full clear: load R1..R7 with 0x11..0x77; pulse clr_req -> busy high exactly 8 cycles, clr_done one pulse, all reads 0x00.
REQ-042 SHALL cover dropped writes: wr_en with R2=0x55 in sweep cycle 4 -> wr_drop pulses, R2 reads 0x00 after the sweep.
REQ-043 SHALL cover reset mid-sweep: rst_n low in sweep cycle 3 -> busy=0, no clr_done pulse, all registers 0, FSM IDLE.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: definitions shared by the multi-port register file and its
// clear sequencer.
//   clr_state_t : sweep FSM states (IDLE, CLEAR)
//   depth_of()  : number of registers addressed by an address of given width
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: sweep sequencer that zeroes every register of the file,
// one address per clock, starting at address 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_req    : start a sweep (ignored while a sweep is running)
//   busy       : high during every cycle the sequencer owns the write port
//   clr_done   : one-cycle pulse in the first idle cycle after a sweep
//   clr_addr   : address being cleared this cycle
//   clr_we     : sweep write strobe (same as busy)
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      clr_done <= done_next;
    end
  end

  // The pointer stops at LAST and the FSM leaves CLEAR on that same edge,
  // so the pointer never wraps and the sweep lasts exactly DEPTH cycles.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_next = IDLE;
          ptr_next   = '0;
          done_next  = 1'b1;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: register file with one write port, NUM_RD registered read
// ports with write-first bypass, optional hardwired-zero register 0 and a
// full-array clear sweep.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data : external write port
//   rd_addr    : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    : packed registered read data, port k at [k*DATA_W +: DATA_W]
//   clr_req    : start a clear sweep
//   busy       : sweep in progress
//   clr_done   : one-cycle pulse when a sweep completes
//   wr_drop    : one-cycle pulse after an external write discarded while busy
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [ADDR_W-1:0]        clr_addr;
  logic                     clr_we;
  logic                     commit;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        w_data;
  logic [NUM_RD*DATA_W-1:0] rd_next;

  regfile_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // The sweep owns the write port while busy; external writes are only
  // accepted in IDLE. Writes to a hardwired register 0 never commit.
  always_comb begin
    w_addr = clr_we ? clr_addr : wr_addr;
    w_data = clr_we ? '0 : wr_data;
    commit = clr_we | (wr_en & ~busy);
    if ((ZERO_R0 != 0) && (w_addr == '0)) begin
      commit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[w_addr] <= w_data;
    end
  end

  // Write-first bypass per port; because commit is suppressed for a
  // hardwired register 0, that address never sees bypass data.
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if ((ZERO_R0 != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
        rd_next[k*DATA_W +: DATA_W] = '0;
      end else if (commit && (rd_addr[k*ADDR_W +: ADDR_W] == w_addr)) begin
        rd_next[k*DATA_W +: DATA_W] = w_data;
      end else begin
        rd_next[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      wr_drop <= 1'b0;
    end else begin
      rd_data <= rd_next;
      wr_drop <= wr_en & busy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp with
// DATA_W=8, ADDR_W=3, NUM_RD=2, ZERO_R0=1.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        clr_req;
  logic        busy;
  logic        clr_done;
  logic        wr_drop;

  int total;
  int bad;
  int busy_cnt;
  int done_cnt;
  int wait_cnt;
  bit seen_done;

  regfile_mp #(
    .DATA_W (8),
    .ADDR_W (3),
    .NUM_RD (2),
    .ZERO_R0(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_done(clr_done),
    .wr_drop (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let one rising edge pass, and return 1 time
  // unit after it so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic we, input logic [2:0] wa,
                               input logic [7:0] wd, input logic [2:0] ra0,
                               input logic [2:0] ra1, input logic clr);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = {ra1, ra0};
    clr_req = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    clr_req = 1'b0;

    // Reset state
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    checkOutput("rst_rd_data", rd_data, 16'h0000);
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_clr_done", {15'd0, clr_done}, 16'd0);
    checkOutput("rst_wr_drop", {15'd0, wr_drop}, 16'd0);
    rst_n = 1'b1;

    // Write then read
    applyStimulus(1, 5, 8'hA7, 0, 0, 0);
    checkOutput("idle_no_drop", {15'd0, wr_drop}, 16'd0);
    applyStimulus(0, 0, 8'h00, 5, 0, 0);
    checkOutput("wr_rd_r5", {8'h00, rd_data[7:0]}, 16'h00A7);

    // Bypass on both ports
    applyStimulus(1, 3, 8'h3C, 3, 3, 0);
    checkOutput("bypass_p0", {8'h00, rd_data[7:0]}, 16'h003C);
    checkOutput("bypass_p1", {8'h00, rd_data[15:8]}, 16'h003C);

    // Register 0 is hardwired to zero, no bypass
    applyStimulus(1, 0, 8'hFF, 0, 0, 0);
    checkOutput("r0_bypass", {8'h00, rd_data[7:0]}, 16'h0000);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    checkOutput("r0_read", {8'h00, rd_data[15:8]}, 16'h0000);

    // Load R1..R7 with 0x11..0x77
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1, 3'(i), 8'(i * 17), 0, 0, 0);
    end
    applyStimulus(0, 0, 8'h00, 7, 1, 0);
    checkOutput("load_r7", {8'h00, rd_data[7:0]}, 16'h0077);
    checkOutput("load_r1", {8'h00, rd_data[15:8]}, 16'h0011);

    // Full clear sweep
    busy_cnt = 0;
    done_cnt = 0;
    applyStimulus(0, 0, 8'h00, 7, 7, 1);
    if (busy) busy_cnt++;
    for (int j = 1; j < 12; j++) begin
      applyStimulus(0, 0, 8'h00, 7, 7, 0);
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (j == 1) checkOutput("clr_read_live", {8'h00, rd_data[7:0]}, 16'h0077);
      if (j == 7) checkOutput("clr_pre_r7", {8'h00, rd_data[15:8]}, 16'h0077);
      if (j == 8) begin
        checkOutput("clr_bypass_r7", {8'h00, rd_data[15:8]}, 16'h0000);
        checkOutput("clr_done_time", {15'd0, clr_done}, 16'd1);
      end
    end
    checkOutput("clr_busy_cycles", 16'(busy_cnt), 16'd8);
    checkOutput("clr_done_pulses", 16'(done_cnt), 16'd1);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 8'h00, 3'(a), 3'(7 - a), 0);
      checkOutput("clr_all_zero", rd_data, 16'h0000);
    end

    // Dropped write in sweep cycle 4, clr_req ignored while busy
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(1, 2, 8'h55, 0, 0, 0);
    checkOutput("drop_pulse", {15'd0, wr_drop}, 16'd1);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("drop_single", {15'd0, wr_drop}, 16'd0);
    wait_cnt  = 0;
    seen_done = 1'b0;
    while (!seen_done && wait_cnt < 20) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 0);
      wait_cnt++;
      if (clr_done) seen_done = 1'b1;
    end
    checkOutput("drop_sweep_len", 16'(wait_cnt), 16'd3);
    applyStimulus(0, 0, 8'h00, 2, 2, 0);
    checkOutput("drop_r2_zero", {8'h00, rd_data[7:0]}, 16'h0000);

    // Simultaneous write and clear request in IDLE
    applyStimulus(1, 4, 8'h44, 4, 4, 1);
    checkOutput("wrclr_bypass", {8'h00, rd_data[7:0]}, 16'h0044);
    checkOutput("wrclr_busy", {15'd0, busy}, 16'd1);
    wait_cnt  = 0;
    seen_done = 1'b0;
    while (!seen_done && wait_cnt < 20) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 0);
      wait_cnt++;
      if (clr_done) seen_done = 1'b1;
    end
    checkOutput("wrclr_done", {15'd0, seen_done}, 16'd1);
    applyStimulus(0, 0, 8'h00, 4, 4, 0);
    checkOutput("wrclr_r4_zero", {8'h00, rd_data[15:8]}, 16'h0000);

    // Reset during sweep cycle 3
    applyStimulus(1, 6, 8'h66, 6, 6, 0);
    checkOutput("pre_rst_r6", {8'h00, rd_data[7:0]}, 16'h0066);
    applyStimulus(0, 0, 8'h00, 6, 6, 1);
    applyStimulus(0, 0, 8'h00, 6, 6, 0);
    applyStimulus(0, 0, 8'h00, 6, 6, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("arst_busy", {15'd0, busy}, 16'd0);
    checkOutput("arst_rd_data", rd_data, 16'h0000);
    applyStimulus(0, 0, 8'h00, 6, 6, 0);
    rst_n    = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      applyStimulus(0, 0, 8'h00, 6, 7, 0);
      if (clr_done) done_cnt++;
      if (busy) busy_cnt++;
    end
    checkOutput("arst_no_done", 16'(done_cnt), 16'd0);
    checkOutput("arst_idle", 16'(busy_cnt), 16'd0);
    checkOutput("arst_r6_r7_zero", rd_data, 16'h0000);

    // Normal operation after reset
    applyStimulus(1, 1, 8'h5A, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 1, 0);
    checkOutput("post_rst_r1", rd_data, 16'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
